// File: rtl/spi_counter_tx_pkg.sv
// Shared types and helpers for the SPI counter transmitter.
// Imported by the transmitter top.
package spi_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } tx_state_t;

    function automatic int tick_div_calc(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/spi_counter_tx_if.sv
// Start/data/ready/done handshake between the counter and the SPI master.
// master = counter side, slave = SPI master side.
interface spi_counter_tx_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              tx_done;

    modport master (
        output start,
        output tx_data,
        input  tx_ready,
        input  tx_done
    );

    modport slave (
        input  start,
        input  tx_data,
        output tx_ready,
        output tx_done
    );
endinterface

// File: rtl/spi_counter_tx_tick_div.sv
// Free-running divider: one-cycle tick every DIV enabled cycles.
// Held at zero while disabled or cleared.
module tick_div #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/spi_counter_tx.sv
// Up/down modulo counter that streams its value to an SPI master,
// coalescing updates that arrive while a frame is still in flight.
module spi_counter_tx
    import spi_counter_pkg::*;
#(
    parameter  int CLK_HZ    = 100_000_000,
    parameter  int TICK_HZ   = 10,
    parameter  int MAX_COUNT = 9999,
    parameter  int DATA_W    = 16,
    localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_toggle,
    input  logic             clear,
    input  logic             down,
    spi_counter_tx_if.master spi,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             drop
);
    localparam int TICK_DIV = tick_div_calc(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);

    generate
        if (CNT_W > DATA_W) begin : g_width_err
            $error("spi_counter_tx: count does not fit in DATA_W");
        end
        if (TICK_DIV < 2) begin : g_div_err
            $error("spi_counter_tx: TICK_DIV must be at least 2");
        end
    endgenerate

    tx_state_t         state;
    tx_state_t         state_d;
    logic              tick;
    logic              step;
    logic              upd;
    logic              load;
    logic              pending;
    logic              start_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_d;

    tick_div #(
        .DIV (TICK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (running),
        .clr  (clear),
        .tick (tick)
    );

    // clear beats run_toggle beats tick
    assign step = tick && !clear && !run_toggle;
    assign upd  = clear || step;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (pending && spi.tx_ready) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND:      state_d = WAIT_DONE;
            WAIT_DONE: if (spi.tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = count;
        if (clear) begin
            cnt_d = down ? MAX_V : '0;
        end else if (step) begin
            if (down) cnt_d = (count == '0) ? MAX_V : count - 1'b1;
            else      cnt_d = (count == MAX_V) ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            running <= 1'b0;
            pending <= 1'b0;
            drop    <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_d;
            count   <= cnt_d;
            if (clear)           running <= 1'b0;
            else if (run_toggle) running <= ~running;
            // an update landing on the load cycle re-arms pending, no drop
            pending <= upd | (pending & ~load);
            drop    <= upd & pending & ~load;
            start_q <= load;
            if (load) data_q <= DATA_W'(count);
        end
    end

    assign spi.start   = start_q;
    assign spi.tx_data = data_q;
endmodule
